// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode-to-rename issue controller.
// Uop bundle width, buffer entry layout and FSM state encoding.
package decode_issue_ctrl_pkg;

  localparam int UOP_W         = 128;
  localparam int DRAIN_MIN_DEF = 3;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic             serial;
    logic [UOP_W-1:0] uop;
  } entry_t;

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Valid/ready uop handshake link with a serial tag.
// Decoder side binds as slave to the controller, rename side as master.
interface decode_issue_ctrl_if;
  import decode_issue_ctrl_pkg::*;

  logic             valid;
  logic             ready;
  logic             serial;
  logic [UOP_W-1:0] uop;

  modport master (
    output valid,
    output uop,
    output serial,
    input  ready
  );

  modport slave (
    input  valid,
    input  uop,
    input  serial,
    output ready
  );

endinterface

// File: rtl/decode_issue_ctrl_fifo2_buf.sv
// Two-entry uop store with wrapping 1-bit pointers.
// Flush clears pointers and count; entry contents are left stale.
module decode_issue_ctrl_fifo2_buf
  import decode_issue_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enq,
  input  logic       deq,
  input  logic       flush,
  input  entry_t     din,
  output entry_t     head,
  output logic [1:0] count
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       head_q, head_d;
  logic       tail_q, tail_d;
  logic [1:0] count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = 1'b0;
      tail_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (enq) begin
        mem_d[tail_q] = din;
        tail_d        = ~tail_q;
      end
      if (deq) begin
        head_d = ~head_q;
      end
      count_d = count_q + {1'b0, enq} - {1'b0, deq};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-rename sequencer: 2-entry buffer, redirect flush,
// and serialization of fence/CSR/ecall-class uops.
module decode_issue_ctrl
  import decode_issue_ctrl_pkg::*;
#(
  parameter int DRAIN_MIN = DRAIN_MIN_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  decode_issue_ctrl_if.slave   dec,
  decode_issue_ctrl_if.master  rn,
  input  logic                 flush_valid,
  input  logic                 backend_empty,
  output logic                 serial_busy,
  output logic [1:0]           occupancy
);

  localparam int DRAIN_W = $clog2(DRAIN_MIN + 1);

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;

  entry_t     head;
  entry_t     din;
  logic [1:0] count;
  logic       enq, deq, head_ok;

  assign din = '{serial: dec.serial, uop: dec.uop};

  decode_issue_ctrl_fifo2_buf u_buf (
    .clock (clock),
    .reset (reset),
    .enq   (enq),
    .deq   (deq),
    .flush (flush_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    if (flush_valid) begin
      state_d     = RUN;
      drain_cnt_d = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (enq && dec.serial) state_d = HOLD;
        end
        HOLD: begin
          if (deq && head.serial) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_W'(DRAIN_MIN);
          end
        end
        DRAIN: begin
          if (drain_cnt_q != '0) drain_cnt_d = drain_cnt_q - 1'b1;
          if (drain_cnt_q == '0 && backend_empty) state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // A serial head waits for an empty backend; older plain uops go freely.
  always_comb begin
    head_ok     = !head.serial || (state_q == HOLD && backend_empty);
    dec.ready   = !flush_valid && state_q == RUN && count != 2'd2;
    rn.valid    = count != 2'd0 && !flush_valid && head_ok
                  && state_q != DRAIN;
    rn.uop      = head.uop;
    rn.serial   = head.serial;
    enq         = dec.valid && dec.ready;
    deq         = rn.valid && rn.ready;
    serial_busy = state_q != RUN;
    occupancy   = count;
  end

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed self-checking bench for decode_issue_ctrl.
// Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
module tb_decode_issue_ctrl;
  import decode_issue_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush_valid;
  logic       backend_empty;
  logic       serial_busy;
  logic [1:0] occupancy;
  int         checks = 0;
  int         errors = 0;

  decode_issue_ctrl_if dec_if ();
  decode_issue_ctrl_if rn_if ();

  decode_issue_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .dec           (dec_if),
    .rn            (rn_if),
    .flush_valid   (flush_valid),
    .backend_empty (backend_empty),
    .serial_busy   (serial_busy),
    .occupancy     (occupancy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [127:0] u,
                       input logic s);
    dec_if.valid  = v;
    dec_if.uop    = u;
    dec_if.serial = s;
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    flush_valid   = 1'b0;
    backend_empty = 1'b0;
    rn_if.ready   = 1'b0;
    dec_if.valid  = 1'b0;
    dec_if.uop    = '0;
    dec_if.serial = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_occ", occupancy, 0);
    chk("rst_valid", rn_if.valid, 0);
    chk("rst_ready", dec_if.ready, 1);
    chk("rst_busy", serial_busy, 0);
    chk("rst_uop", rn_if.uop, 0);

    // Async reset while full
    tick();
    drive(1, 128'h11, 0);
    tick();
    drive(1, 128'h22, 0);
    tick();
    drive(0, 0, 0);
    chk("pre_rst_occ", occupancy, 2);
    reset = 1'b1;
    #1;
    chk("arst_occ", occupancy, 0);
    chk("arst_valid", rn_if.valid, 0);
    reset = 1'b0;
    #1;
    chk("arst_ready", dec_if.ready, 1);

    // Backpressure: A,B buffered, C held
    tick();
    drive(1, 128'hA, 0);
    chk("bp_rdy_a", dec_if.ready, 1);
    tick();
    drive(1, 128'hB, 0);
    chk("bp_valid_a", rn_if.valid, 1);
    chk("bp_uop_a", rn_if.uop, 128'hA);
    chk("bp_occ1", occupancy, 1);
    tick();
    drive(1, 128'hC, 0);
    chk("bp_occ2", occupancy, 2);
    chk("bp_rdy_full", dec_if.ready, 0);
    tick();
    chk("bp_hold_occ", occupancy, 2);
    rn_if.ready = 1'b1;
    #1;
    chk("full_deq_rdy", dec_if.ready, 0);
    chk("drain_a", rn_if.uop, 128'hA);
    tick();
    chk("drain_b", rn_if.uop, 128'hB);
    chk("accept_c", dec_if.ready, 1);
    tick();
    drive(0, 0, 0);
    chk("drain_c_v", rn_if.valid, 1);
    chk("drain_c", rn_if.uop, 128'hC);
    tick();
    chk("bp_empty", occupancy, 0);

    // Streaming at count=1
    drive(1, 128'h100, 0);
    tick();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 128'h100 + i, 0);
      chk("str_occ", occupancy, 1);
      chk("str_valid", rn_if.valid, 1);
      chk("str_uop", rn_if.uop, 128'h100 + i - 1);
      chk("str_rdy", dec_if.ready, 1);
      tick();
    end
    drive(0, 0, 0);
    chk("str_last", rn_if.uop, 128'h10A);
    tick();
    chk("str_empty", occupancy, 0);

    // Serial uop behind A, backend busy
    drive(1, 128'hA1, 0);
    tick();
    drive(1, 128'h5E, 1);
    chk("ser_a_issue", rn_if.uop, 128'hA1);
    chk("ser_acc", dec_if.ready, 1);
    tick();
    drive(1, 128'hD0, 0);
    chk("hold_busy", serial_busy, 1);
    chk("hold_rdy", dec_if.ready, 0);
    chk("hold_valid", rn_if.valid, 0);
    tick();
    chk("hold_valid2", rn_if.valid, 0);
    backend_empty = 1'b1;
    #1;
    chk("ser_issue", rn_if.valid, 1);
    chk("ser_uop", rn_if.uop, 128'h5E);
    chk("ser_tag", rn_if.serial, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("drain_rdy", dec_if.ready, 0);
      chk("drain_busy", serial_busy, 1);
      if (i < 3) tick();
    end
    backend_empty = 1'b0;
    #1;
    tick();
    chk("drain_wait_be", dec_if.ready, 0);
    backend_empty = 1'b1;
    #1;
    chk("drain_last", dec_if.ready, 0);
    tick();
    chk("run_rdy", dec_if.ready, 1);
    chk("run_busy", serial_busy, 0);
    tick();
    drive(0, 0, 0);
    chk("after_d", rn_if.uop, 128'hD0);
    chk("after_d_v", rn_if.valid, 1);
    tick();

    // Flush with count=2 in HOLD
    rn_if.ready   = 1'b0;
    backend_empty = 1'b0;
    drive(1, 128'hE1, 0);
    tick();
    drive(1, 128'hE2, 1);
    tick();
    drive(0, 0, 0);
    chk("fl_occ2", occupancy, 2);
    chk("fl_hold", serial_busy, 1);
    flush_valid = 1'b1;
    #1;
    chk("fl_valid", rn_if.valid, 0);
    chk("fl_rdy", dec_if.ready, 0);
    tick();
    flush_valid = 1'b0;
    #1;
    chk("fl_occ0", occupancy, 0);
    chk("fl_busy", serial_busy, 0);
    chk("fl_rdy_after", dec_if.ready, 1);

    // Flush alongside enq and deq attempts
    rn_if.ready = 1'b1;
    drive(1, 128'hF1, 0);
    tick();
    flush_valid = 1'b1;
    drive(1, 128'hF2, 0);
    chk("fl2_rdy", dec_if.ready, 0);
    chk("fl2_valid", rn_if.valid, 0);
    tick();
    flush_valid = 1'b0;
    drive(0, 0, 0);
    chk("fl2_occ", occupancy, 0);
    chk("fl2_valid_after", rn_if.valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
